// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the PC through fetch (req/ack to instruction memory),
// issue (valid/ready to decode) and advance (single pc_incr pulse per instruction).
module fetch_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_incr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              err,
  input  logic              clear_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_ADV,
    S_ERR
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               single_q;
  logic               single_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [DATA_W-1:0]  instr_d;

  assign mem_addr = pc;

  // Next-state, wait counter, single-step flag and instruction capture.
  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    cnt_d    = '0;
    instr_d  = instr;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_FETCH;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          instr_d = mem_data;
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = S_ERR;
          single_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_d = S_ADV;
        end
      end
      S_ADV: begin
        if (run && !single_q) begin
          state_d = S_FETCH;
        end else begin
          state_d  = S_IDLE;
          single_d = 1'b0;
        end
      end
      S_ERR: begin
        if (clear_err) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        single_d = 1'b0;
      end
    endcase
  end

  // State register; outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      single_q    <= 1'b0;
      cnt_q       <= '0;
      instr       <= '0;
      pc_incr     <= 1'b0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      single_q    <= single_d;
      cnt_q       <= cnt_d;
      instr       <= instr_d;
      pc_incr     <= (state_d == S_ADV);
      mem_req     <= (state_d == S_FETCH);
      instr_valid <= (state_d == S_ISSUE);
      busy        <= (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_ADV);
      err         <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC block and memory models, directed scenarios and
// a randomized run checked against transaction-level expectations.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic              step;
  logic [ADDR_W-1:0] pc;
  logic              pc_incr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              busy;
  logic              err;
  logic              clear_err;

  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              incr_q;
  logic [1:0]        ack_mode;
  logic              ack_man;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .pc(pc),
    .pc_incr(pc_incr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .busy(busy), .err(err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // PC block: increments on the rising edge of incr, loadable by the bench.
  always @(posedge clk) begin
    incr_q <= pc_incr;
    if (pc_load) pc <= pc_load_val;
    else if (pc_incr && !incr_q) pc <= pc + 8'd1;
  end

  // Memory: data is a fixed function of address; ack is never / same-cycle / manual.
  assign mem_data = 16'hA000 + DATA_W'(mem_addr);
  assign mem_ack  = (ack_mode == 2'd1) ? mem_req : (ack_mode == 2'd2) ? ack_man : 1'b0;

  task automatic test_reset;
    run = 1'b1; step = 1'b0; clear_err = 1'b0; instr_ready = 1'b1;
    ack_mode = 2'd1; ack_man = 1'b0; reset = 1'b0;
    pc_load = 1'b1; pc_load_val = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({pc_incr, mem_req, instr_valid, busy, err} !== 5'b0 || instr !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got flags=%b instr=%h want 00000/0000",
               {pc_incr, mem_req, instr_valid, busy, err}, instr);
    end
    reset = 1'b1; pc_load = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: got req=%b busy=%b addr=%h want 1 1 00", mem_req, busy, mem_addr);
    end
  endtask

  // Zero-wait stream: FETCH, ISSUE, ADV repeating with pc stepping by one.
  task automatic test_stream;
    logic [7:0] e_pc;
    e_pc = 8'h00;
    for (int k = 0; k < 9; k++) begin
      total++;
      case (k % 3)
        0: if (mem_req !== 1'b1 || mem_addr !== e_pc || pc_incr !== 1'b0 || instr_valid !== 1'b0) begin
             bad++;
             $display("FAIL stream_fetch k=%0d: got req=%b addr=%h incr=%b want 1 %h 0", k, mem_req, mem_addr, pc_incr, e_pc);
           end
        1: if (instr_valid !== 1'b1 || instr !== 16'hA000 + 16'(e_pc) || mem_req !== 1'b0 || pc_incr !== 1'b0) begin
             bad++;
             $display("FAIL stream_issue k=%0d: got valid=%b instr=%h want 1 %h", k, instr_valid, instr, 16'hA000 + 16'(e_pc));
           end
        default: begin
          if (pc_incr !== 1'b1 || instr_valid !== 1'b0 || pc !== e_pc) begin
            bad++;
            $display("FAIL stream_adv k=%0d: got incr=%b valid=%b pc=%h want 1 0 %h", k, pc_incr, instr_valid, pc, e_pc);
          end
          e_pc = e_pc + 8'd1;
        end
      endcase
      @(negedge clk);
    end
    total++;
    if (pc !== 8'h03 || mem_addr !== 8'h03 || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL stream_pc: got pc=%h addr=%h req=%b want 03 03 1", pc, mem_addr, mem_req);
    end
  endtask

  // run drops while fetching: instruction still completes, then IDLE.
  task automatic test_run_drop;
    run = 1'b0;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || instr !== 16'hA003) begin
      bad++;
      $display("FAIL drop_issue: got valid=%b instr=%h want 1 a003", instr_valid, instr);
    end
    @(negedge clk);
    total++;
    if (pc_incr !== 1'b1) begin
      bad++;
      $display("FAIL drop_adv: got incr=%b want 1", pc_incr);
    end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || pc !== 8'h04 || pc_incr !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: got busy=%b req=%b pc=%h incr=%b want 0 0 04 0", busy, mem_req, pc, pc_incr);
    end
  endtask

  task automatic test_stall;
    logic [DATA_W-1:0] held;
    instr_ready = 1'b0; ack_mode = 2'd1; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h04) begin
      bad++;
      $display("FAIL stall_fetch: got req=%b addr=%h want 1 04", mem_req, mem_addr);
    end
    @(negedge clk);
    held = instr;
    total++;
    if (held !== 16'hA004) begin
      bad++;
      $display("FAIL stall_instr: got %h want a004", held);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr !== 16'hA004 || pc_incr !== 1'b0 || pc !== 8'h04) begin
        bad++;
        $display("FAIL stall_hold i=%0d: got valid=%b instr=%h incr=%b pc=%h want 1 a004 0 04", i, instr_valid, instr, pc_incr, pc);
      end
      if (i < 4) @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    total++;
    if (pc_incr !== 1'b1 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: got incr=%b valid=%b want 1 0", pc_incr, instr_valid);
    end
    repeat (2) @(negedge clk);
    total++;
    if (pc !== 8'h05 || busy !== 1'b0 || pc_incr !== 1'b0) begin
      bad++;
      $display("FAIL stall_once: got pc=%h busy=%b incr=%b want 05 0 0", pc, busy, pc_incr);
    end
  endtask

  task automatic test_step;
    pc_load = 1'b1; pc_load_val = 8'h10;
    @(negedge clk);
    pc_load = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin
      bad++;
      $display("FAIL step_fetch: got req=%b addr=%h want 1 10", mem_req, mem_addr);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || instr !== 16'hA010) begin
      bad++;
      $display("FAIL step_issue: got valid=%b instr=%h want 1 a010", instr_valid, instr);
    end
    @(negedge clk);
    total++;
    if (pc_incr !== 1'b1) begin
      bad++;
      $display("FAIL step_adv: got incr=%b want 1", pc_incr);
    end
    repeat (4) @(negedge clk);
    total++;
    if (pc !== 8'h11 || busy !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL step_single: got pc=%h busy=%b req=%b want 11 0 0", pc, busy, mem_req);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h11) begin
      bad++;
      $display("FAIL step_second: got req=%b addr=%h want 1 11", mem_req, mem_addr);
    end
    repeat (4) @(negedge clk);
    total++;
    if (pc !== 8'h12 || busy !== 1'b0) begin
      bad++;
      $display("FAIL step_second_done: got pc=%h busy=%b want 12 0", pc, busy);
    end
  endtask

  task automatic test_timeout;
    int n;
    pc_load = 1'b1; pc_load_val = 8'h42;
    @(negedge clk);
    pc_load = 1'b0; ack_mode = 2'd0; run = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (err === 1'b1) break;
      if (mem_req === 1'b1) n++;
    end
    total++;
    if (err !== 1'b1 || n != TIMEOUT || mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_err: got err=%b fetch_cycles=%0d req=%b busy=%b want 1 %0d 0 0", err, n, mem_req, busy, TIMEOUT);
    end
    step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    total++;
    if (err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_hold: got err=%b req=%b busy=%b want 1 0 0", err, mem_req, busy);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0; ack_mode = 2'd1;
    total++;
    if (err !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got err=%b req=%b want 0 0", err, mem_req);
    end
    @(negedge clk);
    run = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h42) begin
      bad++;
      $display("FAIL timeout_refetch: got req=%b addr=%h want 1 42", mem_req, mem_addr);
    end
    repeat (4) @(negedge clk);
    total++;
    if (pc !== 8'h43 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_done: got pc=%h busy=%b want 43 0", pc, busy);
    end
  endtask

  // Ack arriving in the last allowed FETCH cycle beats the timeout.
  task automatic test_ack_at_timeout;
    ack_mode = 2'd2; ack_man = 1'b0; run = 1'b1;
    @(negedge clk);
    repeat (TIMEOUT - 1) @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL edge_still_fetch: got req=%b err=%b want 1 0", mem_req, err);
    end
    ack_man = 1'b1; run = 1'b0;
    @(negedge clk);
    ack_man = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || err !== 1'b0 || instr !== 16'hA043) begin
      bad++;
      $display("FAIL edge_ack_wins: got valid=%b err=%b instr=%h want 1 0 a043", instr_valid, err, instr);
    end
    repeat (3) @(negedge clk);
    total++;
    if (pc !== 8'h44 || busy !== 1'b0) begin
      bad++;
      $display("FAIL edge_done: got pc=%h busy=%b want 44 0", pc, busy);
    end
  endtask

  task automatic test_reset_in_issue;
    ack_mode = 2'd1; instr_ready = 1'b0; run = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_issue_reached: got valid=%b want 1", instr_valid);
    end
    reset = 1'b0; run = 1'b0;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || pc_incr !== 1'b0 || busy !== 1'b0 || instr !== 16'h0 || pc !== 8'h44) begin
      bad++;
      $display("FAIL rst_issue: got valid=%b incr=%b busy=%b instr=%h pc=%h want 0 0 0 0000 44", instr_valid, pc_incr, busy, instr, pc);
    end
    reset = 1'b1; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (pc !== 8'h44 || mem_req !== 1'b0 || pc_incr !== 1'b0) begin
      bad++;
      $display("FAIL rst_issue_after: got pc=%h req=%b incr=%b want 44 0 0", pc, mem_req, pc_incr);
    end
  endtask

  // Random ack latency / ready backpressure / spurious handshakes, across pc wrap.
  task automatic test_random;
    int         n_instr;
    int         accepted;
    int         cyc;
    int         wait_c;
    logic       prev_req;
    logic       exp_incr;
    logic       exp_valid;
    logic [7:0] start;
    logic [7:0] exp_pc;
    n_instr = 30; accepted = 0; cyc = 0; wait_c = 0;
    prev_req = 1'b0; exp_incr = 1'b0; exp_valid = 1'b0;
    start = 8'(8'hE0 + 8'($urandom_range(0, 31)));
    exp_pc = start;
    pc_load = 1'b1; pc_load_val = start;
    @(negedge clk);
    pc_load = 1'b0; ack_mode = 2'd2; ack_man = 1'b0; run = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      total++;
      if (pc_incr !== exp_incr) begin
        bad++;
        $display("FAIL rand_incr cyc=%0d: got %b want %b", cyc, pc_incr, exp_incr);
      end
      if (exp_valid) begin
        total++;
        if (instr_valid !== 1'b1) begin
          bad++;
          $display("FAIL rand_ack_to_issue cyc=%0d: got valid=%b want 1", cyc, instr_valid);
        end
      end
      if (instr_valid === 1'b1) begin
        total++;
        if (instr !== 16'hA000 + 16'(exp_pc)) begin
          bad++;
          $display("FAIL rand_instr cyc=%0d: got %h want %h", cyc, instr, 16'hA000 + 16'(exp_pc));
        end
      end
      if (mem_req === 1'b1) begin
        total++;
        if (mem_addr !== exp_pc) begin
          bad++;
          $display("FAIL rand_addr cyc=%0d: got %h want %h", cyc, mem_addr, exp_pc);
        end
      end
      if (accepted == n_instr && busy === 1'b0 && !exp_incr) break;
      if (mem_req === 1'b1) begin
        if (!prev_req) wait_c = $urandom_range(0, 10);
        ack_man = (wait_c == 0);
        if (wait_c > 0) wait_c--;
      end else begin
        ack_man = 1'($urandom_range(0, 1));
      end
      instr_ready = 1'($urandom_range(0, 1));
      prev_req  = mem_req;
      exp_valid = mem_req && ack_man;
      exp_incr  = instr_valid && instr_ready;
      if (exp_incr) begin
        accepted++;
        exp_pc = exp_pc + 8'd1;
        if (accepted == n_instr) run = 1'b0;
      end
    end
    total++;
    if (cyc >= 3000 || accepted != n_instr || pc !== 8'(start + 8'(n_instr))) begin
      bad++;
      $display("FAIL rand_final: got cycles=%0d accepted=%0d pc=%h want <3000 %0d %h", cyc, accepted, pc, n_instr, 8'(start + 8'(n_instr)));
    end
    ack_man = 1'b0; instr_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_run_drop;
    test_stall;
    test_step;
    test_timeout;
    test_ack_at_timeout;
    test_reset_in_issue;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
